// File: rtl/fft_pkg.sv
// Shared FFT datapath types: lane count, lane-select width, complex sample.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fft_pkg;

  localparam int NUM_LANES  = 5;
  localparam int SEL_WIDTH  = 3;
  localparam int CPLX_WIDTH = 16;

  // Complex sample at the default datapath width, shared with the 5:1 selector.
  typedef struct packed {
    logic [CPLX_WIDTH-1:0] re;
    logic [CPLX_WIDTH-1:0] im;
  } cplx_t;

  function automatic logic sel_legal(input logic [SEL_WIDTH-1:0] sel);
    return (sel < NUM_LANES);
  endfunction

endpackage

// File: rtl/complex_reg_slice.sv
// One-deep valid/ready holding register for a single complex sample.
// Latency: 1 cycle from load to valid.
// Backpressure: holds data while valid && !ready; a load on the drain cycle refills with no bubble.
module complex_reg_slice
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_real,
  input  logic [DATA_WIDTH-1:0] load_imag,
  output logic                  valid,
  input  logic                  ready,
  output logic [DATA_WIDTH-1:0] data_real,
  output logic [DATA_WIDTH-1:0] data_imag
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] re;
    logic [DATA_WIDTH-1:0] im;
  } sample_t;

  sample_t held;

  // The parent only asserts load when the slot is empty or draining this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      held  <= '0;
    end else if (load) begin
      valid   <= 1'b1;
      held.re <= load_real;
      held.im <= load_imag;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

  assign data_real = held.re;
  assign data_imag = held.im;

endmodule

// File: rtl/demux1_5_complex_stream.sv
// 1:5 complex sample distributor into per-lane one-deep registers; DEMUX_DROP_CNT_EN adds drop_cnt.
// Latency: 1 cycle input transfer to out_valid.
// Backpressure: in_ready follows only the selected lane; illegal selects are always accepted and discarded.
module demux1_5_complex_stream
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 16
`ifdef DEMUX_DROP_CNT_EN
  ,
  parameter int CNT_WIDTH  = 16
`endif
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH-1:0]           in_real,
  input  logic [DATA_WIDTH-1:0]           in_imag,
  input  logic [SEL_WIDTH-1:0]            in_sel,
  output logic [NUM_LANES-1:0]            out_valid,
  input  logic [NUM_LANES-1:0]            out_ready,
  output logic [NUM_LANES*DATA_WIDTH-1:0] out_real,
  output logic [NUM_LANES*DATA_WIDTH-1:0] out_imag
`ifdef DEMUX_DROP_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]            drop_cnt
`endif
);

  logic                 legal;
  logic                 xfer;
  logic [NUM_LANES-1:0] sel_onehot;
  logic [NUM_LANES-1:0] lane_load;

  assign legal = sel_legal(in_sel);

  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      sel_onehot[i] = (in_sel == SEL_WIDTH'(i));
    end
  end

  // Only the addressed lane gates the input, so a stalled lane never blocks its neighbours.
  assign in_ready  = legal ? |(sel_onehot & (~out_valid | out_ready)) : 1'b1;
  assign xfer      = in_valid && in_ready;
  assign lane_load = xfer ? sel_onehot : '0;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    complex_reg_slice #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_slice (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (lane_load[g]),
      .load_real (in_real),
      .load_imag (in_imag),
      .valid     (out_valid[g]),
      .ready     (out_ready[g]),
      .data_real (out_real[g*DATA_WIDTH +: DATA_WIDTH]),
      .data_imag (out_imag[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end

`ifdef DEMUX_DROP_CNT_EN
  // Saturating count of discarded illegal-select samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (xfer && !legal && (drop_cnt != {CNT_WIDTH{1'b1}})) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end
`else
  a_no_illegal_xfer: assert property (@(posedge clk) disable iff (!rst_n)
    (in_valid && in_ready) |-> legal);
`endif

endmodule
